// File: rtl/data_comparator_seq.sv
// Sequential magnitude comparator: latches two WIDTH-bit operands and compares
// them CHUNK bits per cycle from the MSB end, stopping at the first difference.
module data_comparator_seq #(
    parameter int WIDTH     = 8,
    parameter int CHUNK     = 2,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             AGTB,
    output logic             AEQB,
    output logic             ALTB
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_err
            $error("data_comparator_seq: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             done_q, done_d;
    logic             agtb_q, agtb_d;
    logic             aeqb_q, aeqb_d;
    logic             altb_q, altb_d;

    logic             sgn_s;
    logic [CHUNK-1:0] a_top_s;
    logic [CHUNK-1:0] b_top_s;
    logic             chunk_ne_s;
    logic             last_s;

    assign sgn_s      = (SIGNED_EN != 0) ? signed_mode : 1'b0;
    // Operands are shifted left after each equal chunk, so the live chunk is always on top.
    assign a_top_s    = a_q[WIDTH-1 -: CHUNK];
    assign b_top_s    = b_q[WIDTH-1 -: CHUNK];
    assign chunk_ne_s = (a_top_s != b_top_s);
    assign last_s     = (idx_q == LAST_IDX);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDXW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            done_q  <= 1'b0;
            agtb_q  <= 1'b0;
            aeqb_q  <= 1'b0;
            altb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            agtb_q  <= agtb_d;
            aeqb_q  <= aeqb_d;
            altb_q  <= altb_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CMP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMP: begin
                if (chunk_ne_s || last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CMP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and result-flag updates
    always_comb begin
        idx_d  = idx_q;
        a_d    = a_q;
        b_d    = b_q;
        done_d = 1'b0;
        agtb_d = agtb_q;
        aeqb_d = aeqb_q;
        altb_d = altb_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Flipping both sign bits maps two's-complement order onto unsigned order.
                    a_d   = sgn_s ? (A ^ MSB_MASK) : A;
                    b_d   = sgn_s ? (B ^ MSB_MASK) : B;
                    idx_d = {IDXW{1'b0}};
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_CMP: begin
                if (chunk_ne_s) begin
                    done_d = 1'b1;
                    agtb_d = (a_top_s > b_top_s);
                    altb_d = (a_top_s < b_top_s);
                    aeqb_d = 1'b0;
                end else if (last_s) begin
                    done_d = 1'b1;
                    agtb_d = 1'b0;
                    altb_d = 1'b0;
                    aeqb_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                    a_d   = a_q << CHUNK;
                    b_d   = b_q << CHUNK;
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    assign busy = (state_q == ST_CMP);
    assign done = done_q;
    assign AGTB = agtb_q;
    assign AEQB = aeqb_q;
    assign ALTB = altb_q;

endmodule
